// File: rtl/countdown_timer.sv
// Down-counting interval timer: loads a tick count on start, decrements once every
// PRESCALE cycles, pulses o_done on expiry. Define COUNTDOWN_TIMER_PERIODIC_EN for auto-reload.
module countdown_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [31:0] i_load_val,
    input  logic        i_periodic,
    output logic        o_busy,
    output logic [31:0] o_remaining,
    output logic        o_done
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam logic [31:0] LP_LAST = 32'(PRESCALE - 1);

    state_t      r_state;
    logic [31:0] r_prescale;
    logic [31:0] r_remaining;
    logic        r_busy;
    logic        r_done;

    logic        w_tick;
    logic        w_accept_start;
    logic        w_reload;
    logic [31:0] w_reload_val;

    assign w_tick         = (r_state == ST_RUN) && (r_prescale == LP_LAST);
    assign w_accept_start = i_start && !i_stop;

`ifdef COUNTDOWN_TIMER_PERIODIC_EN
    logic [31:0] r_reload;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_reload <= '0;
        end else if (w_accept_start && (i_load_val != '0)) begin
            r_reload <= i_load_val;
        end
    end

    assign w_reload     = i_periodic;
    assign w_reload_val = r_reload;
`else
    logic w_unused_periodic;

    assign w_unused_periodic = i_periodic;
    assign w_reload          = 1'b0;
    assign w_reload_val      = '0;
`endif

    // NOTE: non-blocking assignments throughout; a later assignment in the same block
    // overrides an earlier one, which is how a restart discards a same-cycle tick.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_prescale  <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_state == ST_RUN) begin
                if (i_stop) begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end else if (w_tick) begin
                    r_prescale <= '0;
                    if (r_remaining > 32'd1) begin
                        r_remaining <= r_remaining - 32'd1;
                    end else begin
                        r_done <= 1'b1;
                        if (w_reload) begin
                            r_remaining <= w_reload_val;
                        end else begin
                            r_remaining <= '0;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end
                    end
                end else begin
                    r_prescale <= r_prescale + 32'd1;
                end
            end

            // Start behaves identically from IDLE and RUN; an expiry pulse above survives it.
            if (w_accept_start) begin
                r_prescale <= '0;
                if (i_load_val != '0) begin
                    r_state     <= ST_RUN;
                    r_busy      <= 1'b1;
                    r_remaining <= i_load_val;
                end else begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_remaining <= '0;
                    r_done      <= 1'b1;
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_remaining = r_remaining;
    assign o_done      = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: three instances (PRESCALE 1, 2, 4) on shared stimulus,
// each compared every cycle against an elapsed-time arithmetic model.
module tb_countdown_timer;

    localparam int NI = 3;
    localparam longint PV [NI] = '{1, 2, 4};
`ifdef COUNTDOWN_TIMER_PERIODIC_EN
    localparam bit PER_EN = 1'b1;
`else
    localparam bit PER_EN = 1'b0;
`endif

    typedef struct {
        bit     active;
        longint s;
        longint n;
        longint rem;
        bit     done;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [31:0] load;
    logic        per;
    logic        busy [NI];
    logic [31:0] rem  [NI];
    logic        done [NI];

    mdl_t   m [NI];
    longint cyc;
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.PRESCALE(1)) u_p1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_load_val(load),
        .i_periodic(per), .o_busy(busy[0]), .o_remaining(rem[0]), .o_done(done[0]));
    countdown_timer #(.PRESCALE(2)) u_p2 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_load_val(load),
        .i_periodic(per), .o_busy(busy[1]), .o_remaining(rem[1]), .o_done(done[1]));
    countdown_timer #(.PRESCALE(4)) u_p4 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_load_val(load),
        .i_periodic(per), .o_busy(busy[2]), .o_remaining(rem[2]), .o_done(done[2]));

    // Remaining count is derived from elapsed cycles since the last accepted start.
    function automatic longint mrem(mdl_t x, longint p, longint c);
        if (!x.active) return x.rem;
        return x.n - ((c - x.s) % (x.n * p)) / p;
    endfunction

    function automatic mdl_t mstep(mdl_t x, longint p, longint c, bit st, bit sp,
                                   longint lv, bit pr);
        mdl_t   r;
        longint el;
        r      = x;
        r.done = 1'b0;
        if (x.active) begin
            el = c - x.s;
            if (sp) begin
                r.active = 1'b0;
                r.rem    = mrem(x, p, c - 1);
            end else if (el % (x.n * p) == 0) begin
                r.done = 1'b1;
                if (!(PER_EN && pr)) begin
                    r.active = 1'b0;
                    r.rem    = 0;
                end
            end
        end
        if (st && !sp) begin
            if (lv == 0) begin
                r.done   = 1'b1;
                r.rem    = 0;
                r.active = 1'b0;
            end else begin
                r.active = 1'b1;
                r.s      = c;
                r.n      = lv;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("p%0d_busy@%0d", PV[k], cyc), {31'd0, busy[k]}, {31'd0, m[k].active});
            check($sformatf("p%0d_done@%0d", PV[k], cyc), {31'd0, done[k]}, {31'd0, m[k].done});
            check($sformatf("p%0d_rem@%0d", PV[k], cyc), rem[k], 32'(mrem(m[k], PV[k], cyc)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (!rst) m[k] = '{default: 0};
            else      m[k] = mstep(m[k], PV[k], cyc, start, stop, longint'(load), per);
        end
        #1;
        check_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; load = '0; per = 1'b0; cyc = 0;
        for (int k = 0; k < NI; k++) m[k] = '{default: 0};
        #12;
        check_all();
        rst = 1'b1;
        step();

        // PRESCALE=4, load 3: 3,2,1,0 every 4 cycles, done and busy fall 12 cycles after start.
        start = 1'b1; load = 32'd3;
        step();
        start = 1'b0;
        check("p4_rem_start", rem[2], 32'd3);
        check("p4_busy_start", {31'd0, busy[2]}, 32'd1);
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("p4_rem_e%0d", i), rem[2], 32'(3 - i / 4));
            check($sformatf("p4_done_e%0d", i), {31'd0, done[2]}, 32'(i == 12));
            check($sformatf("p4_busy_e%0d", i), {31'd0, busy[2]}, 32'(i < 12));
        end
        step();
        check("p4_done_after", {31'd0, done[2]}, 32'd0);

        // PRESCALE=1, load 0: immediate done, busy stays low.
        start = 1'b1; load = 32'd0;
        step();
        start = 1'b0;
        check("p1_zero_done", {31'd0, done[0]}, 32'd1);
        check("p1_zero_busy", {31'd0, busy[0]}, 32'd0);
        step();
        check("p1_zero_done_once", {31'd0, done[0]}, 32'd0);

        // PRESCALE=2, load 10, stop at cycle 7 holds remaining=7.
        start = 1'b1; load = 32'd10;
        step();
        start = 1'b0;
        repeat (6) step();
        check("p2_rem_c6", rem[1], 32'd7);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("p2_stop_busy", {31'd0, busy[1]}, 32'd0);
        check("p2_stop_rem", rem[1], 32'd7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("p2_stop_nodone", {31'd0, done[1]}, 32'd0);
            check("p2_stop_hold", rem[1], 32'd7);
        end

        // PRESCALE=1, load 5 then restart with 2 at cycle 3: done 2 cycles later only.
        start = 1'b1; load = 32'd5;
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1; load = 32'd2;
        step();
        start = 1'b0;
        check("p1_restart_rem", rem[0], 32'd2);
        check("p1_restart_nodone", {31'd0, done[0]}, 32'd0);
        step();
        check("p1_restart_done_early", {31'd0, done[0]}, 32'd0);
        step();
        check("p1_restart_done", {31'd0, done[0]}, 32'd1);
        check("p1_restart_busy", {31'd0, busy[0]}, 32'd0);
        repeat (10) step();

`ifdef COUNTDOWN_TIMER_PERIODIC_EN
        // Periodic reload: done at 3, 6, 9 with busy held high.
        per = 1'b1; start = 1'b1; load = 32'd3;
        step();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("p1_per_done_%0d", i), {31'd0, done[0]}, 32'(i % 3 == 0));
            check($sformatf("p1_per_busy_%0d", i), {31'd0, busy[0]}, 32'd1);
        end
        stop = 1'b1;
        step();
        stop = 1'b0; per = 1'b0;
`endif

        // Asynchronous reset mid-run, then no done without a new start.
        start = 1'b1; load = 32'd5;
        step();
        start = 1'b0;
        repeat (2) step();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("p%0d_arst_busy", PV[k]), {31'd0, busy[k]}, 32'd0);
            check($sformatf("p%0d_arst_done", PV[k]), {31'd0, done[k]}, 32'd0);
            check($sformatf("p%0d_arst_rem", PV[k]), rem[k], 32'd0);
            m[k] = '{default: 0};
        end
        repeat (2) step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("p4_post_rst_done", {31'd0, done[2]}, 32'd0);
            check("p4_post_rst_busy", {31'd0, busy[2]}, 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            load  = 32'($urandom_range(0, 6));
            per   = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting interval timer with a cycle prescaler. It loads a tick count on `start`, decrements it once every `PRESCALE` clock cycles, and pulses `done` when the count reaches zero. It is the consumer-side counterpart of the free-running up-counter timebase. Game-logic FSMs use it for timeouts, cooldowns and delays.

## Interface
- `PRESCALE`, default 1: clock cycles per tick; legal range 1..2^32-1.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low; `rst`=0 clears all state immediately.
- `start`  in  1: load `load_val` and begin counting; sampled per cycle.
- `stop`  in  1: abort the countdown; the remaining count is held.
- `load_val`  in  32: tick count to load on `start`.
- `periodic`  in  1: auto-reload request; used only when the periodic macro is defined.
- `busy`  out  1: high while in RUN.
- `remaining`  out  32: current tick count; holds its value in IDLE.
- `done`  out  1: single-cycle expiry pulse, registered.

## Operation
- Reset values: `busy`=0, `done`=0, `remaining`=0, prescaler=0, state IDLE, reload register=0.
- States: IDLE and RUN.
- Prescaler: internal 32-bit counter, 0..PRESCALE-1. It runs only in RUN. It clears on any start.
  - A tick occurs on the cycle the prescaler equals PRESCALE-1.
  - On that cycle the prescaler returns to 0.
- IDLE, `start`=1, `load_val`>0: go to RUN; `remaining`<=`load_val`; reload register<=`load_val`; prescaler<=0.
- IDLE, `start`=1, `load_val`=0: `done` pulses on the next cycle; the block stays in IDLE; `remaining`<=0.
- RUN, tick, `remaining`>1: `remaining` decrements by 1.
- RUN, tick, `remaining`=1: `remaining`<=0, `done`<=1, then:
  - with periodic reload active: `remaining`<=reload register and the block stays in RUN;
  - otherwise: go to IDLE.
- RUN, `stop`=1: go to IDLE. `remaining` keeps its pre-edge value. No `done` pulse. `stop` wins over a tick in the same cycle.
- RUN, `start`=1, `stop`=0: restart with the new `load_val`, exactly as from IDLE. Any tick in that cycle is discarded.
- `start` and `stop` in the same cycle: `stop` wins; the block ends in IDLE.
- Expiry cycle with `start`=1: `done` still pulses; the restart takes effect and the block stays in RUN with the new value.
- `stop` in IDLE: no effect.
- Arithmetic: 32-bit unsigned. `remaining` never underflows and never goes below 0.

## Timing
- Latency: `start` sampled at edge E with `load_val`=N (N>0). `done` is high for exactly one cycle after edge E+N*PRESCALE.
- `busy` rises at edge E and falls at edge E+N*PRESCALE (non-periodic).
- `remaining` shows N after E, then N-1 after E+PRESCALE, and so on.
- PRESCALE=1: `remaining` decrements every cycle.
- Periodic mode: `done` repeats every N*PRESCALE cycles, with no gap cycle.
- `rst` asserted mid-run: all outputs go to reset values asynchronously. Counting resumes only on a new `start` after `rst` is deasserted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `COUNTDOWN_TIMER_PERIODIC_EN`.
- Defined: the reload register and reload path are compiled in. Reload is active when `periodic`=1 on the expiry cycle.
- Undefined: `periodic` is ignored. Expiry always returns to IDLE. The reload register is omitted.

## Test plan
- PRESCALE=4, start with `load_val`=3 -> `done` pulses 12 cycles after the start edge. `remaining` steps 3,2,1,0 every 4 cycles. `busy` falls with `done`.
- PRESCALE=1, start with `load_val`=0 -> `done` pulses on the next cycle. `busy` stays 0.
- PRESCALE=2, `load_val`=10, `stop` at cycle 7 -> IDLE with `remaining`=7 (ticks at 2,4,6). No `done` pulse.
- PRESCALE=1, `load_val`=5, second start with `load_val`=2 at cycle 3 -> `done` 2 cycles after the restart edge. No earlier `done`.
- Macro defined, PRESCALE=1, `load_val`=3, `periodic`=1 -> `done` at cycles 3, 6, 9. `busy` stays 1.
- `rst`=0 asynchronously mid-run -> `busy`, `done` and `remaining` are 0 before the next clock edge. After deassert, no `done` without a new `start`.
